// File: rtl/demux1x4_16b_buf_pkg.sv
// Shared constants and helpers for the 1:4 buffered demultiplexer.
// Channel select encoding and the select decoder live here so the top and bench agree.
package demux1x4_16b_buf_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int DEPTH_DEF = 2;
   localparam int NUM_CH    = 4;

   typedef enum logic [1:0] {
      CH0 = 2'b00,
      CH1 = 2'b01,
      CH2 = 2'b10,
      CH3 = 2'b11
   } ch_sel_e;

   function automatic logic [NUM_CH-1:0] sel_decode(input logic [1:0] sel);
      logic [NUM_CH-1:0] oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/demux1x4_16b_buf_fifo.sv
// Synchronous FIFO used as one output channel buffer; head word is zero when empty.
// Push is ignored when full, pop is ignored when empty, and reset wins over both.
module fifo_sync_16b
   import demux1x4_16b_buf_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_en;
   logic             pop_en;

   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == CW'(DEPTH));
      push_en = push && !full;
      pop_en  = pop && !empty;
      count   = count_q;
      dout    = empty ? '0 : mem_q[rd_ptr_q];
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/demux1x4_16b_buf.sv
// 1:4 demultiplexer that steers a 16-bit stream into one of four per-channel FIFOs.
// Holds only select decode, IN_READY selection and push gating; buffering is in the FIFOs.
module demux1x4_16b_buf
   import demux1x4_16b_buf_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  A,
   input  logic [1:0]        SEL,
   input  logic              IN_VALID,
   output logic              IN_READY,
   output logic [WIDTH-1:0]  D0,
   output logic [WIDTH-1:0]  D1,
   output logic [WIDTH-1:0]  D2,
   output logic [WIDTH-1:0]  D3,
   output logic [NUM_CH-1:0] OUT_VALID,
   input  logic [NUM_CH-1:0] OUT_READY
);

   localparam int CW = $clog2(DEPTH) + 1;

   // Handshake: a word moves on a rising edge only when its valid and ready are both high
   // there; the producer holds A/SEL until accepted, and IN_READY never looks at OUT_READY.
   logic [NUM_CH-1:0] sel_oh;
   logic [NUM_CH-1:0] push_w;
   logic [NUM_CH-1:0] full_w;
   logic [NUM_CH-1:0] empty_w;
   logic [WIDTH-1:0]  dout_w  [NUM_CH];
   logic [CW-1:0]     count_w [NUM_CH];
   logic              in_fire;

   always_comb begin
      sel_oh   = sel_decode(SEL);
      IN_READY = !rst && (count_w[SEL] < CW'(DEPTH));
      in_fire  = IN_VALID && IN_READY;
      for (int i = 0; i < NUM_CH; i++) begin
         push_w[i] = in_fire && sel_oh[i] && !full_w[i];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      fifo_sync_16b #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push_w[g]),
         .din   (A),
         .full  (full_w[g]),
         .pop   (OUT_READY[g]),
         .dout  (dout_w[g]),
         .empty (empty_w[g]),
         .count (count_w[g])
      );
      assign OUT_VALID[g] = !empty_w[g];
   end

   assign D0 = dout_w[0];
   assign D1 = dout_w[1];
   assign D2 = dout_w[2];
   assign D3 = dout_w[3];

endmodule
